program_loader: RTL and testbench

- Writer-side counterpart to the fetch path (program counter -> memory controller -> program RAM).
- Accepts a byte stream containing a length header, big-endian 16-bit program words and an XOR checksum.
- Writes each assembled word into program RAM through the memory controller's external address/data inputs.
- On a good checksum, raises a level run-enable for the execution driver. Execution stays blocked until a valid image is loaded.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared state encoding and framing constants for the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package program_loader_pkg;

  localparam int BYTES_PER_WORD = 2;
  localparam int LEN_BITS       = 8 * BYTES_PER_WORD;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    CHECK   = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } state_e;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Byte-stream program image loader; writes big-endian words to
//               program RAM and enables execution on a matching XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MEMORY_DEPTH  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     ram_write,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     execution_enable,
  output logic [ADDRESS_WIDTH-1:0] words_loaded
);

  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MEMORY_DEPTH);

  state_e                   state_q;
  logic [LEN_BITS-1:0]      length_q;
  logic [7:0]               word_hi_q;
  logic [7:0]               checksum_q;
  logic [ADDRESS_WIDTH-1:0] words_loaded_q;
  logic                     ram_write_q;
  logic [ADDRESS_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0]    ram_data_q;
  logic                     done_q;
  logic                     error_q;

  logic                     accept;
  logic [LEN_BITS-1:0]      len_full;
  logic [ADDRESS_WIDTH-1:0] words_next;

  assign byte_ready = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign busy       = !(state_q inside {IDLE, DONE, ERROR});
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {length_q[LEN_BITS-1:8], byte_data};
  assign words_next = words_loaded_q + ADDRESS_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      length_q       <= '0;
      word_hi_q      <= '0;
      checksum_q     <= '0;
      words_loaded_q <= '0;
      ram_write_q    <= 1'b0;
      ram_address_q  <= '0;
      ram_data_q     <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q        <= LEN_HI;
            length_q       <= '0;
            checksum_q     <= '0;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            length_q[LEN_BITS-1:8] <= byte_data;
            state_q                <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            length_q <= len_full;
            if (len_full > MAX_LEN) begin
              error_q <= 1'b1;
              state_q <= ERROR;
            end else if (len_full == '0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            word_hi_q  <= byte_data;
            checksum_q <= checksum_q ^ byte_data;
            state_q    <= DATA_LO;
          end
        end
        DATA_LO: begin
          // Strobe, address and data are registered here so they are stable for the whole WRITE cycle.
          if (accept) begin
            checksum_q    <= checksum_q ^ byte_data;
            ram_write_q   <= 1'b1;
            ram_address_q <= words_loaded_q;
            ram_data_q    <= DATA_WIDTH'({word_hi_q, byte_data});
            state_q       <= WRITE;
          end
        end
        WRITE: begin
          ram_write_q    <= 1'b0;
          words_loaded_q <= words_next;
          state_q        <= (words_next == ADDRESS_WIDTH'(length_q)) ? CHECK : DATA_HI;
        end
        CHECK: begin
          if (accept) begin
            if (byte_data == checksum_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              error_q <= 1'b1;
              state_q <= ERROR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_write        = ram_write_q;
  assign ram_address      = ram_address_q;
  assign ram_data         = ram_data_q;
  assign done             = done_q;
  assign error            = error_q;
  assign execution_enable = done_q;
  assign words_loaded     = words_loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        ram_write;
  logic [15:0] ram_address;
  logic [15:0] ram_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        execution_enable;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  logic [15:0] img[0:3];

  program_loader #(
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH   (16),
    .MEMORY_DEPTH (64)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .ram_write       (ram_write),
    .ram_address     (ram_address),
    .ram_data        (ram_data),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .execution_enable(execution_enable),
    .words_loaded    (words_loaded)
  );

  always #5 clock = ~clock;

  // One entry per cycle with the strobe high, so a stretched pulse shows up as extra writes.
  always @(negedge clock) begin
    if (ram_write === 1'b1) begin
      wr_addr_log.push_back(ram_address);
      wr_data_log.push_back(ram_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // All tasks begin and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    n = 0;
    if (stall) begin
      byte_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_stall got %b expected 1", busy);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout got byte_ready=%b expected 1", byte_ready);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic load(input int n, input bit stall, input logic [7:0] chk);
    logic [15:0] len;
    len = 16'(n);
    pulse_start();
    send_byte(len[15:8], stall);
    send_byte(len[7:0], stall);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], stall);
      send_byte(img[i][7:0], stall);
    end
    send_byte(chk, stall);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({ram_write, busy, done, error, execution_enable, byte_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {ram_write, busy, done, error, execution_enable, byte_ready});
    end
    checks++;
    if ({ram_address, ram_data, words_loaded} !== 48'h0) begin
      errors++;
      $display("FAIL reset_regs got addr=%h data=%h words=%h expected 0", ram_address, ram_data, words_loaded);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_nominal();
    int base;
    base = wr_addr_log.size();
    img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h00FF;
    load(3, 1'b0, 8'hBF);  // 12^34^AB^CD^00^FF = BF
    checks++;
    if (wr_addr_log.size() - base !== 3) begin
      errors++;
      $display("FAIL nominal_write_count got %0d expected 3", wr_addr_log.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr_log[base+i] !== 16'(i) || wr_data_log[base+i] !== img[i]) begin
        errors++;
        $display("FAIL nominal_write%0d got addr=%h data=%h expected addr=%h data=%h",
                 i, wr_addr_log[base+i], wr_data_log[base+i], 16'(i), img[i]);
      end
    end
    checks++;
    if ({done, execution_enable, error, busy} !== 4'b1100 || words_loaded !== 16'd3) begin
      errors++;
      $display("FAIL nominal_result got done/en/err/busy=%b words=%0d expected 1100 words=3",
               {done, execution_enable, error, busy}, words_loaded);
    end
  endtask

  task automatic test_restart_from_done();
    int base;
    base = wr_addr_log.size();
    start = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({execution_enable, done, busy} !== 3'b001) begin
      errors++;
      $display("FAIL restart_same_edge got en/done/busy=%b expected 001", {execution_enable, done, busy});
    end
    @(negedge clock);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h00, 1'b0);  // correct checksum would be FF
    checks++;
    if ({error, execution_enable, done} !== 3'b100 || words_loaded !== 16'd1) begin
      errors++;
      $display("FAIL restart_badsum got err/en/done=%b words=%0d expected 100 words=1",
               {error, execution_enable, done}, words_loaded);
    end
    checks++;
    if (wr_addr_log.size() - base !== 1 || wr_addr_log[base] !== 16'h0 || wr_data_log[base] !== 16'h55AA) begin
      errors++;
      $display("FAIL restart_write got count=%0d addr=%h data=%h expected 1 0000 55aa",
               wr_addr_log.size() - base, wr_addr_log[base], wr_data_log[base]);
    end
  endtask

  task automatic test_zero_length();
    int base;
    base = wr_addr_log.size();
    load(0, 1'b0, 8'h00);
    checks++;
    if ({done, execution_enable, error} !== 3'b110 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL zero_len_good got done/en/err=%b words=%0d expected 110 words=0",
               {done, execution_enable, error}, words_loaded);
    end
    load(0, 1'b0, 8'h01);
    checks++;
    if ({done, execution_enable, error} !== 3'b001) begin
      errors++;
      $display("FAIL zero_len_bad got done/en/err=%b expected 001", {done, execution_enable, error});
    end
    checks++;
    if (wr_addr_log.size() !== base) begin
      errors++;
      $display("FAIL zero_len_writes got %0d expected 0", wr_addr_log.size() - base);
    end
  endtask

  task automatic test_oversize();
    int base;
    base = wr_addr_log.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    checks++;
    if ({error, done, byte_ready, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL oversize got err/done/ready/busy=%b expected 1000", {error, done, byte_ready, busy});
    end
    repeat (2) @(negedge clock);
    checks++;
    if (wr_addr_log.size() !== base) begin
      errors++;
      $display("FAIL oversize_writes got %0d expected 0", wr_addr_log.size() - base);
    end
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    checks++;
    if ({error, byte_ready, busy} !== 3'b011) begin
      errors++;
      $display("FAIL len_at_depth got err/ready/busy=%b expected 011", {error, byte_ready, busy});
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_stalls();
    int base;
    base = wr_addr_log.size();
    img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h00FF;
    load(3, 1'b1, 8'hBF);
    checks++;
    if (wr_addr_log.size() - base !== 3) begin
      errors++;
      $display("FAIL stall_write_count got %0d expected 3", wr_addr_log.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr_log[base+i] !== 16'(i) || wr_data_log[base+i] !== img[i]) begin
        errors++;
        $display("FAIL stall_write%0d got addr=%h data=%h expected addr=%h data=%h",
                 i, wr_addr_log[base+i], wr_data_log[base+i], 16'(i), img[i]);
      end
    end
    checks++;
    if ({done, execution_enable, error} !== 3'b110 || words_loaded !== 16'd3) begin
      errors++;
      $display("FAIL stall_result got done/en/err=%b words=%0d expected 110 words=3",
               {done, execution_enable, error}, words_loaded);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    base = wr_addr_log.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h12, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ram_write, busy, done, error, execution_enable, byte_ready} !== 6'b0 ||
        {ram_address, ram_data, words_loaded} !== 48'h0) begin
      errors++;
      $display("FAIL midload_reset got flags=%b addr=%h data=%h words=%h expected all 0",
               {ram_write, busy, done, error, execution_enable, byte_ready}, ram_address, ram_data, words_loaded);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (wr_addr_log.size() !== base || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_after got writes=%0d busy=%b expected 0 0", wr_addr_log.size() - base, busy);
    end
    img[0] = 16'hBEEF; img[1] = 16'h0102;
    load(2, 1'b0, 8'h52);  // BE^EF^01^02 = 52
    checks++;
    if (wr_addr_log.size() - base !== 2 || wr_data_log[base] !== 16'hBEEF || wr_data_log[base+1] !== 16'h0102 ||
        wr_addr_log[base+1] !== 16'h1 || done !== 1'b1) begin
      errors++;
      $display("FAIL midload_reload got count=%0d d0=%h d1=%h a1=%h done=%b expected 2 beef 0102 0001 1",
               wr_addr_log.size() - base, wr_data_log[base], wr_data_log[base+1], wr_addr_log[base+1], done);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_nominal();
    test_restart_from_done();
    test_zero_length();
    test_oversize();
    test_stalls();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
